// File: rtl/bytecode_decoder.sv
// Bytecode decoder/executor: takes one opcode per start/ready handshake and runs it on a local int operand stack.
// Build option DECODER_STICKY_ERR_EN: unsupported/underflow/overflow flags stay set until reset.
module bytecode_decoder #(
    parameter int width_in    = 8,
    parameter int data_width  = 32,
    parameter int stack_size  = 8,
    parameter int depth_width = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start_for_decoder,
    input  logic [width_in-1:0]    data_for_decoder,
    output logic                   ready_from_decoder,
    output logic [data_width-1:0]  top_of_stack,
    output logic [depth_width-1:0] stack_depth,
    output logic                   op_done,
    output logic                   unsupported,
    output logic                   err_underflow,
    output logic                   err_overflow
);

    localparam int IDX_W = (stack_size > 1) ? $clog2(stack_size) : 1;
    localparam logic [depth_width-1:0] FULL = depth_width'(stack_size);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC
    } state_e;

    typedef enum logic [3:0] {
        OP_NOP,
        OP_CONST,
        OP_POP,
        OP_DUP,
        OP_ADD,
        OP_SUB,
        OP_MUL,
        OP_NEG,
        OP_I2B,
        OP_UNSUP
    } op_e;

    state_e                        state_q, state_d;
    logic [width_in-1:0]           opcode_q, opcode_d;
    op_e                           class_q, class_d;
    logic                          chk_under_q, chk_under_d;
    logic                          chk_over_q, chk_over_d;
    logic signed [data_width-1:0]  stack_q [stack_size];
    logic signed [data_width-1:0]  stack_d [stack_size];
    logic [depth_width-1:0]        depth_q, depth_d;
    logic                          done_q, done_d;
    logic                          unsup_q, unsup_d;
    logic                          under_q, under_d;
    logic                          over_q, over_d;

    logic [IDX_W-1:0]              top_idx, sec_idx, push_idx;
    logic signed [data_width-1:0]  opa, opb, res;
    op_e                           dec_class;
    logic                          fault;

    function automatic op_e classify(input logic [7:0] op);
        op_e c;
        case (op)
            8'h00:                                           c = OP_NOP;
            8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08: c = OP_CONST;
            8'h57:                                           c = OP_POP;
            8'h59:                                           c = OP_DUP;
            8'h60:                                           c = OP_ADD;
            8'h64:                                           c = OP_SUB;
            8'h68:                                           c = OP_MUL;
            8'h74:                                           c = OP_NEG;
            8'h91:                                           c = OP_I2B;
            default:                                         c = OP_UNSUP;
        endcase
        return c;
    endfunction

    // iconst_m1..iconst_5 encode their value as opcode - 3
    function automatic logic signed [data_width-1:0] const_val(input logic [7:0] op);
        logic signed [7:0] c;
        c = $signed(op - 8'd3);
        return {{(data_width-8){c[7]}}, c};
    endfunction

    function automatic logic signed [data_width-1:0] sext_byte(input logic [7:0] v);
        return {{(data_width-8){v[7]}}, v};
    endfunction

    assign top_idx  = IDX_W'(depth_q - 1'b1);
    assign sec_idx  = IDX_W'(depth_q - 2'd2);
    assign push_idx = IDX_W'(depth_q);
    assign opb      = stack_q[top_idx];
    assign opa      = stack_q[sec_idx];
    assign dec_class = classify(8'(opcode_q));

    always_comb begin
        state_d     = state_q;
        opcode_d    = opcode_q;
        class_d     = class_q;
        chk_under_d = chk_under_q;
        chk_over_d  = chk_over_q;
        stack_d     = stack_q;
        depth_d     = depth_q;
        done_d      = 1'b0;
        unsup_d     = unsup_q;
        under_d     = under_q;
        over_d      = over_q;
        res         = '0;
        fault       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_for_decoder) begin
                    opcode_d = data_for_decoder;
                    state_d  = S_DECODE;
                end
            end

            S_DECODE: begin
                class_d     = dec_class;
                chk_under_d = 1'b0;
                chk_over_d  = 1'b0;
                case (dec_class)
                    OP_POP, OP_NEG, OP_I2B: chk_under_d = (depth_q == '0);
                    OP_DUP: begin
                        chk_under_d = (depth_q == '0);
                        chk_over_d  = (depth_q == FULL);
                    end
                    OP_ADD, OP_SUB, OP_MUL: chk_under_d = (depth_q < depth_width'(2));
                    OP_CONST:               chk_over_d  = (depth_q == FULL);
                    default: ;
                endcase
                state_d = S_EXEC;
            end

            S_EXEC: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
                fault   = (class_q == OP_UNSUP) || chk_under_q || chk_over_q;
                if (!fault) begin
                    case (class_q)
                        OP_CONST: begin
                            stack_d[push_idx] = const_val(8'(opcode_q));
                            depth_d           = depth_q + 1'b1;
                        end
                        OP_DUP: begin
                            stack_d[push_idx] = opb;
                            depth_d           = depth_q + 1'b1;
                        end
                        OP_POP: depth_d = depth_q - 1'b1;
                        OP_ADD, OP_SUB, OP_MUL: begin
                            if (class_q == OP_ADD)      res = opa + opb;
                            else if (class_q == OP_SUB) res = opa - opb;
                            else                        res = opa * opb;
                            stack_d[sec_idx] = res;
                            depth_d          = depth_q - 1'b1;
                        end
                        OP_NEG: stack_d[top_idx] = -opb;
                        OP_I2B: stack_d[top_idx] = sext_byte(opb[7:0]);
                        default: ;
                    endcase
                end
`ifdef DECODER_STICKY_ERR_EN
                unsup_d = unsup_q | (class_q == OP_UNSUP);
                under_d = under_q | chk_under_q;
                over_d  = over_q  | chk_over_q;
`else
                unsup_d = (class_q == OP_UNSUP);
                under_d = chk_under_q;
                over_d  = chk_over_q;
`endif
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            opcode_q    <= '0;
            class_q     <= OP_NOP;
            chk_under_q <= 1'b0;
            chk_over_q  <= 1'b0;
            for (int i = 0; i < stack_size; i++) stack_q[i] <= '0;
            depth_q     <= '0;
            done_q      <= 1'b0;
            unsup_q     <= 1'b0;
            under_q     <= 1'b0;
            over_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            opcode_q    <= opcode_d;
            class_q     <= class_d;
            chk_under_q <= chk_under_d;
            chk_over_q  <= chk_over_d;
            stack_q     <= stack_d;
            depth_q     <= depth_d;
            done_q      <= done_d;
            unsup_q     <= unsup_d;
            under_q     <= under_d;
            over_q      <= over_d;
        end
    end

    assign ready_from_decoder = (state_q == S_IDLE);
    assign top_of_stack       = (depth_q == '0) ? '0 : opb;
    assign stack_depth        = depth_q;
    assign op_done            = done_q;
    assign unsupported        = unsup_q;
    assign err_underflow      = under_q;
    assign err_overflow       = over_q;

endmodule
